// File: rtl/one_wire_pkg.sv
// Shared types and constants for the 1-wire UID transmit path.
// Holds the sequencer state encoding, the Dallas/Maxim CRC polynomial and the default widths.
package one_wire_pkg;

    localparam int DEFAULT_UID_WIDTH = 56;
    localparam int DEFAULT_CRC_WIDTH = 8;

    // Reflected form of x^8 + x^5 + x^4 + 1, used with a right-shifting register.
    localparam logic [7:0] CRC_POLY = 8'h8C;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_DATA = 3'd2,
        ST_CRC  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/one_wire_crc8.sv
// Serial Dallas/Maxim CRC, one bit per enabled cycle, LSB-first data.
// The clear input has priority over the enable input.
module one_wire_crc8
    import one_wire_pkg::*;
#(
    parameter int              WIDTH = DEFAULT_CRC_WIDTH,
    parameter logic [WIDTH-1:0] POLY = WIDTH'(CRC_POLY)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             data_bit,
    output logic [WIDTH-1:0] crc
);

    logic fb;

    assign fb = crc[0] ^ data_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= (crc >> 1) ^ (fb ? POLY : '0);
        end
    end

endmodule

// File: rtl/uid_tx_sequencer.sv
// Serialises a UID payload followed by its CRC onto 1-wire bit slots, one bit per bit_tick.
// Handshake: a frame is taken on any cycle where cmd_valid and cmd_ready are both high.
module uid_tx_sequencer
    import one_wire_pkg::*;
#(
    parameter int UID_SERIAL_DATA_WIDTH = DEFAULT_UID_WIDTH,
    parameter int CRC_WIDTH             = DEFAULT_CRC_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [UID_SERIAL_DATA_WIDTH-1:0] uid_data,
    input  logic                             bit_tick,
    input  logic                             abort,
    output logic                             tx_bit,
    output logic                             tx_en,
    output logic                             busy,
    output logic                             done,
    output logic                             aborted,
    output logic [CRC_WIDTH-1:0]             crc_out,
    output state_t                           fsm_state
);

    localparam int CNT_W     = $clog2(UID_SERIAL_DATA_WIDTH);
    localparam int CRC_IDX_W = $clog2(CRC_WIDTH);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(UID_SERIAL_DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(CRC_WIDTH - 1);

    state_t                           state, state_nxt;
    logic [CNT_W-1:0]                 cnt, cnt_nxt;
    logic [UID_SERIAL_DATA_WIDTH-1:0] payload, payload_nxt;
    logic                             tx_bit_nxt, tx_en_nxt;
    logic                             done_nxt, aborted_nxt;
    logic [CRC_WIDTH-1:0]             crc_out_nxt;
    logic [CRC_WIDTH-1:0]             crc_q;
    logic                             crc_clr, crc_en;
    logic                             payload_bit, crc_bit;

    assign payload_bit = payload[cnt];
    assign crc_bit     = crc_q[cnt[CRC_IDX_W-1:0]];
    assign cmd_ready   = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign fsm_state   = state;

    one_wire_crc8 #(
        .WIDTH (CRC_WIDTH)
    ) u_crc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (crc_clr),
        .en       (crc_en),
        .data_bit (payload_bit),
        .crc      (crc_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            payload <= '0;
            tx_bit  <= 1'b0;
            tx_en   <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
            crc_out <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            payload <= payload_nxt;
            tx_bit  <= tx_bit_nxt;
            tx_en   <= tx_en_nxt;
            done    <= done_nxt;
            aborted <= aborted_nxt;
            crc_out <= crc_out_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        payload_nxt = payload;
        tx_bit_nxt  = tx_bit;
        tx_en_nxt   = tx_en;
        done_nxt    = 1'b0;
        aborted_nxt = 1'b0;
        crc_out_nxt = crc_out;
        crc_clr     = 1'b0;
        crc_en      = 1'b0;

        // Abort outranks everything once a frame is under way, including a pending tick.
        if (state != ST_IDLE && abort) begin
            state_nxt   = ST_IDLE;
            cnt_nxt     = '0;
            tx_en_nxt   = 1'b0;
            aborted_nxt = 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        payload_nxt = uid_data;
                        cnt_nxt     = '0;
                        crc_clr     = 1'b1;
                        state_nxt   = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state_nxt = ST_DATA;
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        tx_bit_nxt = payload_bit;
                        tx_en_nxt  = 1'b1;
                        crc_en     = 1'b1;
                        if (cnt == DATA_LAST) begin
                            cnt_nxt   = '0;
                            state_nxt = ST_CRC;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
                ST_CRC: begin
                    // The CRC register is no longer enabled here, so it stays frozen.
                    if (bit_tick) begin
                        tx_bit_nxt = crc_bit;
                        tx_en_nxt  = 1'b1;
                        if (cnt == CRC_LAST) begin
                            cnt_nxt   = '0;
                            tx_en_nxt = 1'b0;
                            state_nxt = ST_DONE;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    done_nxt    = 1'b1;
                    crc_out_nxt = crc_q;
                    state_nxt   = ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uid_tx_sequencer.sv
// Directed bench for uid_tx_sequencer: full frames, abort, async reset, handshake holding.
// Expected tx_bit streams come from the payload constants and hand-computed CRC values.
module tb_uid_tx_sequencer;
    import one_wire_pkg::*;

    localparam int UW = 56;
    localparam int CW = 8;
    localparam logic [UW-1:0] UID_A = 56'h00_0000_01B8_1C02;
    localparam logic [CW-1:0] CRC_A = 8'hA2;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [UW-1:0] uid_data;
    logic          bit_tick;
    logic          abort;
    logic          tx_bit;
    logic          tx_en;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [CW-1:0] crc_out;
    state_t        fsm_state;

    int   n_cmp     = 0;
    int   n_err     = 0;
    int   done_cnt  = 0;
    int   abort_cnt = 0;
    int   acc_cnt   = 0;
    int   acc0;
    logic exp_q[$];

    uid_tx_sequencer #(
        .UID_SERIAL_DATA_WIDTH (UW),
        .CRC_WIDTH             (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .uid_data  (uid_data),
        .bit_tick  (bit_tick),
        .abort     (abort),
        .tx_bit    (tx_bit),
        .tx_en     (tx_en),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .crc_out   (crc_out),
        .fsm_state (fsm_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse and handshake monitors, sampled mid-cycle.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (aborted) abort_cnt++;
        if (rst_n && cmd_valid && cmd_ready) acc_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_exp(input logic [UW-1:0] d, input logic [CW-1:0] c);
        for (int i = 0; i < UW; i++) exp_q.push_back(d[i]);
        for (int i = 0; i < CW; i++) exp_q.push_back(c[i]);
    endtask

    // Issue n ticks; gap idle cycles between ticks check that tx_bit holds.
    task automatic tick_bits(input int n, input int gap);
        logic e;
        for (int i = 0; i < n; i++) begin
            bit_tick = 1'b1;
            step();
            bit_tick = 1'b0;
            e = exp_q.pop_front();
            check($sformatf("tx_bit[%0d]", i), 64'(tx_bit), 64'(e));
            check($sformatf("tx_en[%0d]", i), 64'(tx_en), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                for (int g = 0; g < gap; g++) begin
                    step();
                    check("tx_bit_hold", 64'(tx_bit), 64'(e));
                end
            end
        end
    endtask

    task automatic accept(input logic [UW-1:0] d);
        cmd_valid = 1'b1;
        uid_data  = d;
        step();
        check("accept_state", 64'(fsm_state), 64'(ST_LOAD));
        check("accept_busy", 64'(busy), 64'd1);
        check("accept_ready", 64'(cmd_ready), 64'd0);
        cmd_valid = 1'b0;
    endtask

    task automatic finish_frame(input logic [CW-1:0] c);
        check("pre_done_state", 64'(fsm_state), 64'(ST_DONE));
        step();
        check("done_pulse", 64'(done), 64'd1);
        check("crc_out", 64'(crc_out), 64'(c));
        check("post_done_state", 64'(fsm_state), 64'(ST_IDLE));
        step();
        check("done_low", 64'(done), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        uid_data  = '0;
        bit_tick  = 1'b0;
        abort     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 64'(fsm_state), 64'(ST_IDLE));
        check("rst_ready", 64'(cmd_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_tx_bit", 64'(tx_bit), 64'd0);
        check("rst_tx_en", 64'(tx_en), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_aborted", 64'(aborted), 64'd0);
        check("rst_crc_out", 64'(crc_out), 64'd0);
        rst_n = 1'b1;
        step();

        // All-zero payload, ticks spaced by one idle cycle.
        accept('0);
        step();
        check("zero_in_data", 64'(fsm_state), 64'(ST_DATA));
        load_exp('0, 8'h00);
        tick_bits(56, 1);
        check("zero_in_crc", 64'(fsm_state), 64'(ST_CRC));
        tick_bits(8, 1);
        finish_frame(8'h00);
        check("zero_done_cnt", 64'(done_cnt), 64'd1);

        // Reference UID, tick during LOAD, then back-to-back ticks.
        accept(UID_A);
        bit_tick = 1'b1;
        step();
        check("load_tick_state", 64'(fsm_state), 64'(ST_DATA));
        check("load_tick_tx_en", 64'(tx_en), 64'd0);
        load_exp(UID_A, CRC_A);
        tick_bits(56, 0);
        check("a_in_crc", 64'(fsm_state), 64'(ST_CRC));
        tick_bits(8, 0);
        finish_frame(CRC_A);
        check("a_done_cnt", 64'(done_cnt), 64'd2);

        // Abort coinciding with the 20th data tick.
        accept('0);
        step();
        load_exp('0, 8'h00);
        tick_bits(19, 0);
        bit_tick = 1'b1;
        abort    = 1'b1;
        step();
        bit_tick = 1'b0;
        abort    = 1'b0;
        exp_q.delete();
        check("abort_pulse", 64'(aborted), 64'd1);
        check("abort_no_done", 64'(done), 64'd0);
        check("abort_state", 64'(fsm_state), 64'(ST_IDLE));
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_tx_en", 64'(tx_en), 64'd0);
        check("abort_crc_out", 64'(crc_out), 64'(CRC_A));
        step();
        check("abort_low", 64'(aborted), 64'd0);
        check("abort_cnt", 64'(abort_cnt), 64'd1);
        check("abort_done_cnt", 64'(done_cnt), 64'd2);

        // Asynchronous reset in the middle of the CRC field.
        accept(UID_A);
        step();
        load_exp(UID_A, CRC_A);
        tick_bits(58, 0);
        check("rst_mid_in_crc", 64'(fsm_state), 64'(ST_CRC));
        #1 rst_n = 1'b0;
        #1;
        check("arst_state", 64'(fsm_state), 64'(ST_IDLE));
        check("arst_ready", 64'(cmd_ready), 64'd1);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_tx_bit", 64'(tx_bit), 64'd0);
        check("arst_tx_en", 64'(tx_en), 64'd0);
        check("arst_crc_out", 64'(crc_out), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_aborted", 64'(aborted), 64'd0);
        #1 rst_n = 1'b1;
        exp_q.delete();
        step();
        check("arst_idle", 64'(fsm_state), 64'(ST_IDLE));
        check("arst_done_cnt", 64'(done_cnt), 64'd2);
        check("arst_abort_cnt", 64'(abort_cnt), 64'd1);

        // Abort while idle is ignored; cmd_valid held across two frames, uid_data changed mid-frame.
        acc0      = acc_cnt;
        cmd_valid = 1'b1;
        abort     = 1'b1;
        uid_data  = UID_A;
        step();
        check("idle_abort_accept", 64'(fsm_state), 64'(ST_LOAD));
        check("idle_abort_no_pulse", 64'(aborted), 64'd0);
        abort    = 1'b0;
        uid_data = '0;
        step();
        load_exp(UID_A, CRC_A);
        tick_bits(56, 0);
        tick_bits(8, 0);
        check("hold_done_ready", 64'(cmd_ready), 64'd0);
        check("hold_state_done", 64'(fsm_state), 64'(ST_DONE));
        step();
        check("hold_done_pulse", 64'(done), 64'd1);
        check("hold_crc_a", 64'(crc_out), 64'(CRC_A));
        check("hold_idle", 64'(fsm_state), 64'(ST_IDLE));
        step();
        check("hold_second_accept", 64'(fsm_state), 64'(ST_LOAD));
        cmd_valid = 1'b0;
        check("hold_acc_cnt", 64'(acc_cnt - acc0), 64'd2);
        step();
        load_exp('0, 8'h00);
        tick_bits(56, 1);
        tick_bits(8, 1);
        finish_frame(8'h00);
        check("final_acc_cnt", 64'(acc_cnt - acc0), 64'd2);
        check("final_done_cnt", 64'(done_cnt), 64'd4);
        check("final_abort_cnt", 64'(abort_cnt), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uid_tx_sequencer.md
UID_TX_SEQUENCER -- requirements
Module: uid_tx_sequencer

Interface
REQ-001 Parameter UID_SERIAL_DATA_WIDTH, default 56, meaning UID payload bits per frame.
REQ-002 Parameter CRC_WIDTH, default 8, meaning CRC bits appended after the payload.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  requester offers a frame.
REQ-006 cmd_ready  output  1  sequencer can accept a frame.
REQ-007 uid_data  input  UID_SERIAL_DATA_WIDTH  payload, sampled on acceptance.
REQ-008 bit_tick  input  1  one-cycle pulse marking a 1-wire bit-slot boundary.
REQ-009 abort  input  1  terminate current frame.
REQ-010 tx_bit  output  1  bit currently driven onto the slot.
REQ-011 tx_en  output  1  tx_bit is valid.
REQ-012 busy  output  1  frame in progress.
REQ-013 done  output  1  one-cycle pulse, frame completed.
REQ-014 aborted  output  1  one-cycle pulse, frame aborted.
REQ-015 crc_out  output  CRC_WIDTH  CRC of the last completed frame.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, DATA, CRC, DONE.
REQ-017 cmd_ready SHALL be high only in IDLE; a frame is accepted on a cycle with cmd_valid and cmd_ready both high.
REQ-018 On acceptance the sequencer SHALL capture uid_data, clear the bit counter and CRC register to 0, and enter LOAD.
REQ-019 LOAD SHALL last exactly one cycle, ignore bit_tick, then go to DATA.
REQ-020 In DATA, each bit_tick SHALL drive tx_bit with payload bit[bit counter] (LSB first), fold it into the CRC, and increment the counter.
REQ-021 CRC update per bit SHALL be: fb = crc[0] XOR bit; crc = crc >> 1; if fb, crc = crc XOR 0x8C (Dallas/Maxim x^8+x^5+x^4+1).
REQ-022 After the tick carrying payload bit UID_SERIAL_DATA_WIDTH-1, the FSM SHALL enter CRC with the counter cleared.
REQ-023 In CRC, each bit_tick SHALL drive tx_bit with the frozen CRC bit[counter], LSB first; after bit CRC_WIDTH-1, the FSM SHALL enter DONE.
REQ-024 DONE SHALL last one cycle, pulse done, load crc_out with the frozen CRC, and return to IDLE.
REQ-025 tx_en SHALL be high in DATA and CRC from the first bit_tick until the state is left; tx_bit SHALL hold between ticks.
REQ-026 busy SHALL be high in LOAD, DATA, CRC and DONE.
REQ-027 abort SHALL take priority over bit_tick and return the FSM to IDLE on the next edge from any non-IDLE state, pulsing aborted, not pulsing done, and leaving crc_out unchanged.
REQ-028 abort in IDLE SHALL have no effect, and cmd_valid on the same cycle SHALL still be accepted.
REQ-029 cmd_valid while busy SHALL be ignored; uid_data changes after acceptance SHALL not affect the frame.
REQ-030 Bit counter width SHALL be clog2(UID_SERIAL_DATA_WIDTH) and SHALL never wrap beyond the last index.

Reset
REQ-031 While rst_n is low: state IDLE; cmd_ready 1; tx_bit, tx_en, busy, done, aborted 0; crc_out 0; counter and CRC register 0.
REQ-032 rst_n asserted mid-frame SHALL discard the frame without a done or aborted pulse.

Structure
REQ-033 The state enum, CRC polynomial constant 0x8C and the default widths SHALL live in the shared package one_wire_pkg.
REQ-034 The serial CRC update SHALL be a sub-module one_wire_crc8 (inputs: clk, rst_n, clr, en, bit; output: crc).

Verification
REQ-035 uid_data=56'h00_0000_01B8_1C02, 64 bit_ticks -> tx_bit sequence is payload LSB-first then CRC; done pulses once; crc_out=8'hA2.
REQ-036 uid_data=0, full frame -> 64 tx_bit zeros; crc_out=8'h00.
REQ-037 abort on the cycle of the 20th DATA tick -> aborted pulse, no done, back in IDLE next cycle, crc_out unchanged from the prior frame.
REQ-038 cmd_valid held high and uid_data changed during a frame -> exactly one acceptance per frame; second frame starts only after DONE returns to IDLE.
REQ-039 rst_n pulsed low during CRC state -> all outputs at reset values asynchronously; a new frame then completes correctly.
REQ-040 bit_tick asserted in LOAD and on back-to-back cycles in DATA -> the LOAD tick is ignored; each consecutive tick advances exactly one bit.
